// File: rtl/register_writeback.sv
// Write-back stage: buffers ALU and load results in an in-order FIFO and
// drains them to the register file write port, one write per cycle.
module register_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_WIDTH-1:0]        alu_da,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [ADDR_WIDTH-1:0]        mem_da,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  input  logic                         hold,
  input  logic                         flush,
  output logic                         RW,
  output logic [ADDR_WIDTH-1:0]        DA,
  output logic [DATA_WIDTH-1:0]        D_data,
  output logic [(2**ADDR_WIDTH)-1:0]   pending,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] fifo_da   [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         offset;
  logic                  not_full;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] push_da;
  logic [DATA_WIDTH-1:0] push_data;

  // Readies look only at the registered count; a same-cycle pop frees nothing.
  assign not_full  = count < FULL;
  assign mem_ready = !flush && not_full;
  assign alu_ready = !flush && not_full && !mem_valid;
  assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign push_da   = mem_valid ? mem_da : alu_da;
  assign push_data = mem_valid ? mem_data : alu_data;
  assign pop       = !hold && !flush && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_da[wr_ptr]   <= push_da;
      fifo_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      RW     <= 1'b0;
      DA     <= '0;
      D_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      RW     <= 1'b0;
    end else begin
      RW <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        DA     <= fifo_da[rd_ptr];
        D_data <= fifo_data[rd_ptr];
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    pending = '0;
    offset  = '0;
    if (RW) pending[DA] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      if ({1'b0, offset} < count) pending[fifo_da[i]] = 1'b1;
    end
  end

endmodule

// File: doc/register_writeback.md
# register_writeback

Write-back stage of the RISC datapath: the writer-side counterpart of the register file's write port. It accepts completed results from the ALU and from the data-memory load path over valid/ready handshakes, buffers them in an in-order FIFO, and drives the register file's RW / DA / D_data write port at one write per cycle. It also publishes a per-register pending mask that operand fetch uses for hazard interlock.

## Interface
- DATA_WIDTH, 16, width of D_data and result data
- ADDR_WIDTH, 3, register address width; register count is 2**ADDR_WIDTH
- DEPTH, 4, FIFO entries; must be a power of two, at least 2
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result offered
- alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high
- alu_da  input  ADDR_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- mem_valid  input  1  load result offered
- mem_ready  output  1  load result accepted this cycle when mem_valid is also high
- mem_da  input  ADDR_WIDTH  load destination register
- mem_data  input  DATA_WIDTH  load data
- hold  input  1  suppresses draining; no register write is issued while high
- flush  input  1  discards all buffered results, synchronously
- RW  output  1  register file write enable, registered
- DA  output  ADDR_WIDTH  register file write address, registered
- D_data  output  DATA_WIDTH  register file write data, registered
- pending  output  2**ADDR_WIDTH  bit i is high while any buffered entry or the current write targets register i
- count  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- Storage:
  - Circular FIFO of {da, data} entries.
  - Read and write pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count tracks occupancy.
- Acceptance (one entry per cycle at most):
  - mem_ready = !flush && count < DEPTH.
  - alu_ready = !flush && count < DEPTH && !mem_valid. Loads have priority, so a concurrent ALU result stalls.
  - A handshake (valid && ready) at an edge writes the entry at the write pointer and advances the pointer.
  - Readies are computed from the current count only. A same-cycle pop does not free a slot.
- Drain, at each edge when !hold && !flush:
  - If count > 0, the head is loaded into DA/D_data, RW is set to 1 and the read pointer advances.
  - If count == 0, RW is set to 0. DA and D_data hold their previous values.
- Drain while hold is high:
  - RW is set to 0 at the next edge.
  - FIFO contents, DA and D_data are held.
  - Acceptance continues until the FIFO is full.
- Simultaneous push and pop: count is unchanged and both pointers advance. This holds at count == DEPTH-1 and at count == 1.
- Flush:
  - At the edge where flush is high, count becomes 0, both pointers become 0 and RW becomes 0.
  - No handshake completes in that cycle because both readies are low.
  - flush overrides hold.
- pending:
  - Combinational OR of the one-hot decodes of every valid FIFO entry's da, plus DA when RW is 1.
  - Duplicate destinations keep their bit set until the last matching entry has been written.
- Writes to every register, including register 0, are issued unchanged. The register file defines the semantics of register 0.
- Ordering: writes reach the register file in acceptance order. A later write to the same register always wins.

## Timing
- Reset (asynchronous assertion, all values held while rst is high):
  - RW=0, DA=0, D_data=0.
  - count=0, pointers=0, pending=0.
  - alu_ready=1 and mem_ready=1 once flush is low.
- Latency:
  - A result accepted at edge k appears on RW/DA/D_data during the cycle after edge k+1, provided the FIFO was empty and hold is low.
  - Each entry already queued ahead of it adds one cycle.
  - Each cycle hold is high adds one cycle.
- Throughput: one accept and one write per cycle in steady state. The FIFO never fills unless hold is asserted or the sources burst while a write is in progress.
- Full: at count == DEPTH both readies are low, even if a pop occurs in the same cycle.
- Empty: at count == 0 there is no bypass. RW drops to 0 one edge after the last entry is drained.
- rst mid-burst: all buffered results are lost. No RW pulse occurs after rst deasserts until a new handshake has completed.

## Test plan
- Single ALU result: after reset, alu_valid=1, alu_da=5, alu_data=16'h1234 for one cycle -> alu_ready=1; two edges later RW=1, DA=5, D_data=16'h1234 for exactly one cycle; pending[5] is high from the accept edge through that write cycle.
- Priority: alu_valid=1 (da=1, data=16'hAAAA) and mem_valid=1 (da=2, data=16'h5555) in the same cycle -> mem accepted and alu_ready=0; alu accepted next cycle; writes occur in the order R2 then R1 on consecutive cycles.
- Fill under hold: hold=1, push 4 ALU results with da 0..3 and data 16'h0010..16'h0013 -> count=4, both readies low, RW stays 0; release hold -> four consecutive RW pulses in order 0..3, then count=0.
- Pointer wrap and concurrent push/pop: stream 10 back-to-back results with data equal to their index -> all 10 written in order, no gaps after the first, count never exceeds 1.
- Flush: queue 3 entries under hold, then pulse flush for one cycle -> count=0, pending=0, no RW pulse afterward; a new push then writes normally.
- Async reset mid-operation: with 2 entries queued and RW=1, assert rst between edges -> RW, DA, D_data and pending are all 0 immediately; no writes occur after rst is released.
